// File: rtl/instr_seq_ctrl_if.sv
// Bundle of signals between the instruction sequencer and the IR/decoder, datapath
// and memory port. The sequencer is the master: it owns every strobe and reads
// start, the decoded instruction fields and the memory ready flag.
//
// Memory handshake: mem_cmd is the request and mem_rdy the response. In a memory
// wait state (IF1, MRD, MWR) the sequencer holds mem_cmd steady. It advances only
// on a rising edge where mem_cmd != 00 and mem_rdy == 1; that edge completes the
// transfer. mem_cmd stays at READ through IF2 and WMEM so the read data remains
// valid while it is captured. mem_rdy is ignored in those two states.
interface instr_seq_ctrl_if;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       mem_rdy;
  logic       w;
  logic       halted;
  logic       err;
  logic       reset_pc;
  logic       load_pc;
  logic       load_ir;
  logic       addr_sel;
  logic       load_addr;
  logic [1:0] mem_cmd;
  logic [1:0] nsel;
  logic [1:0] vsel;
  logic       loada;
  logic       loadb;
  logic       loadc;
  logic       loads;
  logic       asel;
  logic       bsel;
  logic       write;

  modport master (
    input  s, opcode, op, mem_rdy,
    output w, halted, err, reset_pc, load_pc, load_ir, addr_sel, load_addr,
           mem_cmd, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write
  );

  modport slave (
    output s, opcode, op, mem_rdy,
    input  w, halted, err, reset_pc, load_pc, load_ir, addr_sel, load_addr,
           mem_cmd, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Moore sequencer for the CPU. It fetches an instruction, decodes {opcode,op} and
// steps through the execute states of MOV/MOVI/ALU/CMP/LDR/STR/HALT. The decoded
// instruction class is latched in DEC, so strobes and branches depend only on
// registers. All outputs are registered copies of the decode of the next state.
module instr_seq_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  instr_seq_ctrl_if.master bus,
  output logic [4:0]       state_dbg
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPC, S_DEC, S_WIMM, S_GA, S_GB, S_CALU, S_WR,
    S_CCMP, S_CADR, S_LADR, S_MRD, S_WMEM, S_GBD, S_CST, S_MWR, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_MOVI, K_MOV, K_ALU, K_CMP, K_MVN, K_LDR, K_STR
  } kind_t;

  typedef struct packed {
    logic       w;
    logic       halted;
    logic       reset_pc;
    logic       load_pc;
    logic       load_ir;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
  } ctl_t;

  state_t        state, state_nxt;
  kind_t         kind, kind_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          err_q, err_nxt;
  ctl_t          ctl;

  // Strobes asserted in each state; asel in CALU zeroes A for MOV/MVN.
  function automatic ctl_t decode(input state_t st, input kind_t k);
    ctl_t c;
    c = '0;
    case (st)
      S_RST:  begin c.w = 1'b1; c.reset_pc = 1'b1; c.load_pc = 1'b1; end
      S_IF1:  begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; end
      S_IF2:  begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; c.load_ir = 1'b1; end
      S_UPC:  c.load_pc = 1'b1;
      S_DEC:  c = '0;
      S_WIMM: begin c.nsel = 2'b00; c.vsel = 2'b01; c.write = 1'b1; end
      S_GA:   begin c.nsel = 2'b00; c.loada = 1'b1; end
      S_GB:   begin c.nsel = 2'b10; c.loadb = 1'b1; end
      S_CALU: begin c.loadc = 1'b1; c.asel = (k == K_MOV) || (k == K_MVN); end
      S_WR:   begin c.nsel = 2'b01; c.vsel = 2'b11; c.write = 1'b1; end
      S_CCMP: c.loads = 1'b1;
      S_CADR: begin c.bsel = 1'b1; c.loadc = 1'b1; end
      S_LADR: c.load_addr = 1'b1;
      S_MRD:  c.mem_cmd = 2'b01;
      S_WMEM: begin c.mem_cmd = 2'b01; c.nsel = 2'b01; c.vsel = 2'b00; c.write = 1'b1; end
      S_GBD:  begin c.nsel = 2'b01; c.loadb = 1'b1; end
      S_CST:  begin c.asel = 1'b1; c.loadc = 1'b1; end
      S_MWR:  c.mem_cmd = 2'b10;
      S_HALT: c.halted = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next state, instruction class, wait counter and sticky error.
  always_comb begin
    state_nxt = state;
    kind_nxt  = kind;
    cnt_nxt   = cnt;
    err_nxt   = err_q;
    case (state)
      S_RST:  if (bus.s) state_nxt = S_IF1;
      S_IF1, S_MRD, S_MWR: begin
        if (bus.mem_rdy) begin
          case (state)
            S_IF1:   state_nxt = S_IF2;
            S_MRD:   state_nxt = S_WMEM;
            default: state_nxt = S_IF1;
          endcase
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HALT;
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_IF2:  state_nxt = S_UPC;
      S_UPC:  state_nxt = S_DEC;
      S_DEC: begin
        casez ({bus.opcode, bus.op})
          5'b110_10: begin kind_nxt = K_MOVI; state_nxt = S_WIMM; end
          5'b110_00: begin kind_nxt = K_MOV;  state_nxt = S_GB;   end
          5'b101_00,
          5'b101_10: begin kind_nxt = K_ALU;  state_nxt = S_GA;   end
          5'b101_01: begin kind_nxt = K_CMP;  state_nxt = S_GA;   end
          5'b101_11: begin kind_nxt = K_MVN;  state_nxt = S_GB;   end
          5'b011_00: begin kind_nxt = K_LDR;  state_nxt = S_GA;   end
          5'b100_00: begin kind_nxt = K_STR;  state_nxt = S_GA;   end
          5'b111_??: begin kind_nxt = K_NONE; state_nxt = S_HALT; end
          default:   begin kind_nxt = K_NONE; state_nxt = S_HALT; err_nxt = 1'b1; end
        endcase
      end
      S_WIMM: state_nxt = S_IF1;
      S_GA:   state_nxt = (kind == K_LDR || kind == K_STR) ? S_CADR : S_GB;
      S_GB:   state_nxt = (kind == K_CMP) ? S_CCMP : S_CALU;
      S_CALU: state_nxt = S_WR;
      S_WR:   state_nxt = S_IF1;
      S_CCMP: state_nxt = S_IF1;
      S_CADR: state_nxt = S_LADR;
      S_LADR: state_nxt = (kind == K_LDR) ? S_MRD : S_GBD;
      S_WMEM: state_nxt = S_IF1;
      S_GBD:  state_nxt = S_CST;
      S_CST:  state_nxt = S_MWR;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_RST;
    endcase
    // Every fresh entry into a memory wait state restarts the timeout count.
    if ((state_nxt != state) &&
        (state_nxt == S_IF1 || state_nxt == S_MRD || state_nxt == S_MWR))
      cnt_nxt = '0;
  end

  // State and output registers; outputs track the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_RST;
      kind  <= K_NONE;
      cnt   <= '0;
      err_q <= 1'b0;
      ctl   <= decode(S_RST, K_NONE);
    end else begin
      state <= state_nxt;
      kind  <= kind_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      ctl   <= decode(state_nxt, kind_nxt);
    end
  end

  assign state_dbg     = state;
  assign bus.err       = err_q;
  assign bus.w         = ctl.w;
  assign bus.halted    = ctl.halted;
  assign bus.reset_pc  = ctl.reset_pc;
  assign bus.load_pc   = ctl.load_pc;
  assign bus.load_ir   = ctl.load_ir;
  assign bus.addr_sel  = ctl.addr_sel;
  assign bus.load_addr = ctl.load_addr;
  assign bus.mem_cmd   = ctl.mem_cmd;
  assign bus.nsel      = ctl.nsel;
  assign bus.vsel      = ctl.vsel;
  assign bus.loada     = ctl.loada;
  assign bus.loadb     = ctl.loadb;
  assign bus.loadc     = ctl.loadc;
  assign bus.loads     = ctl.loads;
  assign bus.asel      = ctl.asel;
  assign bus.bsel      = ctl.bsel;
  assign bus.write     = ctl.write;

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Directed bench for instr_seq_ctrl (WAIT_MAX=4). Each step pushes the control
// vector expected after the next rising edge, then pops and compares it #1 later.
module tb_instr_seq_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] state_dbg;

  instr_seq_ctrl_if bus ();

  instr_seq_ctrl #(.WAIT_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  typedef enum {
    B_RST, B_IF1, B_IF2, B_UPC, B_DEC, B_WIMM, B_GA, B_GB, B_CALU, B_WR,
    B_CCMP, B_CADR, B_LADR, B_MRD, B_WMEM, B_GBD, B_CST, B_MWR, B_HALT
  } bstate_t;

  typedef struct packed {
    logic       w;
    logic       halted;
    logic       err;
    logic       reset_pc;
    logic       load_pc;
    logic       load_ir;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
  } vec_t;

  logic [20:0] exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        exp_err = 1'b0;
  int          write_seen = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference strobe table.
  function automatic logic [20:0] spec_vec(input bstate_t st, input logic am, input logic e);
    vec_t v;
    v = '0;
    v.err = e;
    case (st)
      B_RST:  begin v.w = 1; v.reset_pc = 1; v.load_pc = 1; end
      B_IF1:  begin v.addr_sel = 1; v.mem_cmd = 2'b01; end
      B_IF2:  begin v.addr_sel = 1; v.mem_cmd = 2'b01; v.load_ir = 1; end
      B_UPC:  v.load_pc = 1;
      B_DEC:  ;
      B_WIMM: begin v.vsel = 2'b01; v.write = 1; end
      B_GA:   v.loada = 1;
      B_GB:   begin v.nsel = 2'b10; v.loadb = 1; end
      B_CALU: begin v.loadc = 1; v.asel = am; end
      B_WR:   begin v.nsel = 2'b01; v.vsel = 2'b11; v.write = 1; end
      B_CCMP: v.loads = 1;
      B_CADR: begin v.bsel = 1; v.loadc = 1; end
      B_LADR: v.load_addr = 1;
      B_MRD:  v.mem_cmd = 2'b01;
      B_WMEM: begin v.mem_cmd = 2'b01; v.nsel = 2'b01; v.write = 1; end
      B_GBD:  begin v.nsel = 2'b01; v.loadb = 1; end
      B_CST:  begin v.asel = 1; v.loadc = 1; end
      B_MWR:  v.mem_cmd = 2'b10;
      B_HALT: v.halted = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [20:0] observed();
    vec_t v;
    v.w = bus.w; v.halted = bus.halted; v.err = bus.err; v.reset_pc = bus.reset_pc;
    v.load_pc = bus.load_pc; v.load_ir = bus.load_ir; v.addr_sel = bus.addr_sel;
    v.load_addr = bus.load_addr; v.mem_cmd = bus.mem_cmd; v.nsel = bus.nsel;
    v.vsel = bus.vsel; v.loada = bus.loada; v.loadb = bus.loadb; v.loadc = bus.loadc;
    v.loads = bus.loads; v.asel = bus.asel; v.bsel = bus.bsel; v.write = bus.write;
    return v;
  endfunction

  // driver + scoreboard: one clock edge, then check the registered outputs
  task automatic step(input bstate_t st, input logic am = 1'b0);
    logic [20:0] obs;
    logic [20:0] expv;
    exp_q.push_back(spec_vec(st, am, exp_err));
    @(posedge clk);
    #1;
    obs  = observed();
    expv = exp_q.pop_front();
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: obs=%h exp=%h", st.name(), obs, expv);
    end
  endtask

  task automatic set_instr(input logic [2:0] opc, input logic [1:0] o);
    bus.opcode = opc;
    bus.op     = o;
  endtask

  task automatic count_check(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: obs=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  // Writes issued between reset and reaching RST during the abort test.
  always @(posedge clk) if (bus.write === 1'b1) write_seen++;

  initial begin
    reset = 1'b0; bus.s = 1'b0; bus.mem_rdy = 1'b1; set_instr(3'b000, 2'b00);

    // Reset, then idle in RST with s=0.
    step(B_RST);
    reset = 1'b1;
    step(B_RST);
    step(B_RST);

    // MOVI, zero-wait.
    set_instr(3'b110, 2'b10); bus.s = 1'b1;
    step(B_IF1); bus.s = 1'b0;
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_WIMM); step(B_IF1);

    // ADD.
    set_instr(3'b101, 2'b00);
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GA); step(B_GB);
    step(B_CALU, 1'b0); step(B_WR); step(B_IF1);

    // CMP: loads once, no write.
    set_instr(3'b101, 2'b01);
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GA); step(B_GB); step(B_CCMP); step(B_IF1);

    // MOV and MVN zero the A operand.
    set_instr(3'b110, 2'b00);
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GB); step(B_CALU, 1'b1); step(B_WR); step(B_IF1);
    set_instr(3'b101, 2'b11);
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GB); step(B_CALU, 1'b1); step(B_WR); step(B_IF1);

    // LDR with three wait cycles in MRD; the final wait sits at the timeout boundary.
    set_instr(3'b011, 2'b00);
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GA); step(B_CADR);
    bus.mem_rdy = 1'b0;
    step(B_LADR); step(B_MRD); step(B_MRD); step(B_MRD); step(B_MRD);
    bus.mem_rdy = 1'b1;
    step(B_WMEM); step(B_IF1);

    // STR, with three wait cycles in IF1 first.
    set_instr(3'b100, 2'b00);
    bus.mem_rdy = 1'b0;
    step(B_IF1); step(B_IF1); step(B_IF1);
    bus.mem_rdy = 1'b1;
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GA); step(B_CADR); step(B_LADR);
    step(B_GBD); step(B_CST); step(B_MWR); step(B_IF1);

    // HALT opcode: no error; s ignored.
    set_instr(3'b111, 2'b01);
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_HALT);
    bus.s = 1'b1;
    step(B_HALT);
    bus.s = 1'b0; reset = 1'b0;
    step(B_RST);
    reset = 1'b1;

    // Fetch timeout: four IF1 cycles with mem_rdy stuck low.
    bus.mem_rdy = 1'b0; bus.s = 1'b1;
    step(B_IF1); bus.s = 1'b0;
    step(B_IF1); step(B_IF1); step(B_IF1);
    exp_err = 1'b1;
    step(B_HALT); step(B_HALT);
    reset = 1'b0; exp_err = 1'b0;
    step(B_RST);
    reset = 1'b1; bus.mem_rdy = 1'b1;

    // Illegal opcode.
    set_instr(3'b000, 2'b00); bus.s = 1'b1;
    step(B_IF1); bus.s = 1'b0;
    step(B_IF2); step(B_UPC); step(B_DEC);
    exp_err = 1'b1;
    step(B_HALT);
    reset = 1'b0; exp_err = 1'b0;
    step(B_RST);
    reset = 1'b1;

    // Reset in CALU abandons the ADD before its write.
    set_instr(3'b101, 2'b00); bus.s = 1'b1;
    step(B_IF1); bus.s = 1'b0;
    step(B_IF2); step(B_UPC); step(B_DEC); step(B_GA); step(B_GB); step(B_CALU, 1'b0);
    write_seen = 0;
    reset = 1'b0;
    step(B_RST);
    reset = 1'b1;
    step(B_RST);
    count_check("abort_write", write_seen, 0);
    count_check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
